time_set_ctrl: RTL and testbench
================================

# time_set_ctrl

Mode/set controller that sequences the digital-clock datapath: it gates the running clock, turns mode and up-button presses into single-cycle hour/minute increment pulses with hold-to-repeat, and drives a per-digit blink mask for the HH:MM seven-segment display. It sits between the button debouncers and the clock counter and seven-segment driver in the top level. It replaces the ad-hoc edge detection now done in the top module.

## Interface
Parameters:
- CLK_HZ, 100_000_000, input clock frequency; the ms prescaler divides by CLK_HZ/1000.
- HOLD_MS, 500, ms that btn_up must be held before auto-repeat starts.
- REPEAT_MS, 150, ms between auto-repeat pulses.
- BLINK_MS, 250, ms per blink half-period.
- TIMEOUT_MS, 10_000, ms of inactivity in a set mode before the block returns to RUN.

Ports:
- clk  in  1  system clock; everything is clocked on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- run_sw  in  1  run-enable switch level.
- btn_mode  in  1  debounced level, synchronous to clk.
- btn_up  in  1  debounced level, synchronous to clk.
- clk_en  out  1  enable to the clock counter; equals run_sw & (mode==RUN).
- hrup  out  1  one-cycle pulse that increments hours.
- minup  out  1  one-cycle pulse that increments minutes.
- sec_clr  out  1  one-cycle pulse that clears seconds.
- digit_blank  out  4  1 blanks a digit; bit3=h2, bit2=h1, bit1=m2, bit0=m1.
- mode  out  2  00 RUN, 01 SET_HR, 10 SET_MIN; 11 is never produced.

## Operation
- FSM states: RUN, SET_HR, SET_MIN.
  - A rising edge of btn_mode steps RUN->SET_HR->SET_MIN->RUN.
  - Leaving SET_MIN, by button or by timeout from either set state, pulses sec_clr in the same cycle the state becomes RUN.
- Edge detection: the previous-value registers reset to 1. A button already held when rst_n releases does not count as a press until it is released and pressed again.
- In RUN, btn_up is ignored: no pulses, repeat counter stays at 0.
- In SET_HR or SET_MIN, a rising edge of btn_up issues one pulse (hrup or minup according to state) and starts the hold counter.
  - While btn_up stays high, the first repeat pulse fires HOLD_MS ms-ticks after the press.
  - Further repeat pulses follow every REPEAT_MS ms-ticks.
  - Releasing btn_up clears the hold counter.
- At most one of hrup/minup is high in any cycle. hrup and minup are never high in RUN.
- Simultaneous rising edges of btn_mode and btn_up: the mode edge wins, no increment pulse is issued, and the hold counter is cleared.
- A mode change while btn_up is held clears the hold counter. The held button then produces nothing until it is re-pressed.
- Blink:
  - A phase bit toggles every BLINK_MS ms-ticks.
  - In SET_HR, digit_blank={phase,phase,0,0}. In SET_MIN, digit_blank={0,0,phase,phase}. In RUN, digit_blank=0000.
  - The phase and blink counter reset to 0 (digits visible) on entry to any set state and on every increment pulse.
- Timeout: an inactivity counter of ms-ticks runs in the set states.
  - It is cleared by any btn_mode or btn_up edge and while btn_up is held.
  - When it reaches TIMEOUT_MS, the state goes to RUN and sec_clr is pulsed.
- Counter widths are $clog2(max value + 1). Counters saturate or reload; they never wrap silently.

## Timing
- Reset values: state RUN, mode 00, clk_en 0, hrup 0, minup 0, sec_clr 0, digit_blank 0000. All counters are 0 and phase is 0.
- After reset, clk_en follows run_sw with 1 cycle of latency because it is registered.
- Button edge on input at cycle N:
  - The state/mode change is visible at N+1.
  - The hrup/minup pulse is high for exactly cycle N+1.
- ms-tick: a one-cycle strobe every CLK_HZ/1000 clocks from a free-running prescaler, which is cleared by reset only. Repeat, blink and timeout intervals are therefore accurate to within -1 ms-tick.
- Asserting rst_n low mid-operation forces all outputs to their reset values immediately, independent of clk. This includes truncating any pulse in progress.

## Structure
- Shared package (clock_pkg): mode encoding constants MODE_RUN/MODE_SETHR/MODE_SETMIN and the ms-tick divisor function.
- Sub-module ms_tick_gen, parameterised by CLK_HZ, outputs the 1 ms strobe. It is reused later by an alarm block.
- The FSM, repeat counter, blink counter and timeout counter live in time_set_ctrl itself. Estimated size is about 200 lines.

## Test plan
All tests use CLK_HZ=4000 (4 clocks per ms-tick).
- Reset with btn_mode held, release rst_n, keep btn_mode high for 20 cycles -> mode stays 00. Then release and press -> mode=01 one cycle after the edge.
- In SET_HR, tap btn_up for 3 cycles -> exactly one hrup pulse, no minup, digit_blank=0000 at the pulse.
- In SET_MIN, hold btn_up for 1000 ms with HOLD_MS=500 and REPEAT_MS=150 -> minup count 1+1+3=5. Repeat pulses fall 500, 650, 800 and 950 ms after the press, each within -1 ms.
- btn_mode and btn_up rise in the same cycle in SET_HR -> mode=10, no hrup, and holding btn_up for 600 ms produces no pulses.
- Stay idle in SET_HR with TIMEOUT_MS=10000 -> mode=00 and a single-cycle sec_clr at 10000 ms (-1). clk_en then tracks run_sw.
- Assert rst_n low in the middle of an auto-repeat burst -> hrup/minup drop in the same cycle, mode=00, digit_blank=0000, and no pulse occurs after release.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock control blocks:
// mode encoding and the millisecond prescaler divisor.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'b00,
    MODE_SETHR  = 2'b01,
    MODE_SETMIN = 2'b10
  } mode_e;

  // Clocks per ms-tick; never below one so very slow clocks still tick.
  function automatic int unsigned ms_tick_div(input int unsigned clk_hz);
    int unsigned div;
    div = clk_hz / 32'd1000;
    return (div < 32'd1) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler producing a one-cycle strobe every millisecond.
// Only the asynchronous reset restarts it.
module ms_tick_gen
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ = 32'd100_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int unsigned DIV = ms_tick_div(CLK_HZ);
  localparam int unsigned CW  = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 32'd1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/time_set_ctrl.sv
// Mode/set sequencer for the HH:MM clock: gates the running clock, turns button
// presses into increment pulses with hold-to-repeat, and drives the digit blink mask.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 32'd100_000_000,
  parameter int unsigned HOLD_MS    = 32'd500,
  parameter int unsigned REPEAT_MS  = 32'd150,
  parameter int unsigned BLINK_MS   = 32'd250,
  parameter int unsigned TIMEOUT_MS = 32'd10_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_sw,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic       clk_en,
  output logic       hrup,
  output logic       minup,
  output logic       sec_clr,
  output logic [3:0] digit_blank,
  output logic [1:0] mode
);

  localparam int unsigned HOLD_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int unsigned HW = $clog2(HOLD_MAX + 32'd1);
  localparam int unsigned BW = $clog2(BLINK_MS + 32'd1);
  localparam int unsigned TW = $clog2(TIMEOUT_MS + 32'd1);

  localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_MS - 32'd1);
  localparam logic [HW-1:0] REPEAT_LAST  = HW'(REPEAT_MS - 32'd1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_MS - 32'd1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_MS - 32'd1);

  logic          w_ms_tick;
  logic          w_mode_rise;
  logic          w_up_rise;
  logic          w_in_set;

  mode_e         r_state;
  mode_e         w_state_nxt;
  logic          r_mode_prev;
  logic          r_up_prev;

  logic [TW-1:0] r_idle_cnt;
  logic [TW-1:0] w_idle_nxt;
  logic          w_timeout;
  logic          w_sec_clr_nxt;

  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_nxt;
  logic [HW-1:0] w_hold_last;
  logic          r_first;
  logic          w_first_nxt;
  logic          r_armed;
  logic          w_armed_nxt;
  logic          w_inc;

  logic [BW-1:0] r_blink_cnt;
  logic [BW-1:0] w_blink_nxt;
  logic          r_phase;
  logic          w_phase_nxt;
  logic [3:0]    w_blank_nxt;

  logic          r_hrup;
  logic          r_minup;
  logic          r_sec_clr;
  logic          r_clk_en;
  logic [3:0]    r_blank;

  ms_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_ms_tick (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .o_tick (w_ms_tick)
  );

  // Previous-value registers reset high so a button held through reset is not a press.
  assign w_mode_rise = btn_mode & ~r_mode_prev;
  assign w_up_rise   = btn_up & ~r_up_prev;
  assign w_in_set    = (r_state == MODE_SETHR) || (r_state == MODE_SETMIN);

  always_comb begin
    w_state_nxt   = r_state;
    w_idle_nxt    = r_idle_cnt;
    w_timeout     = 1'b0;
    w_sec_clr_nxt = 1'b0;
    case (r_state)
      MODE_RUN: begin
        w_idle_nxt = '0;
        if (w_mode_rise) begin
          w_state_nxt = MODE_SETHR;
        end else begin
          w_state_nxt = MODE_RUN;
        end
      end
      MODE_SETHR, MODE_SETMIN: begin
        if (w_mode_rise || w_up_rise || btn_up) begin
          w_idle_nxt = '0;
        end else if (w_ms_tick && (r_idle_cnt == TIMEOUT_LAST)) begin
          w_idle_nxt = '0;
          w_timeout  = 1'b1;
        end else if (w_ms_tick) begin
          w_idle_nxt = r_idle_cnt + TW'(1);
        end else begin
          w_idle_nxt = r_idle_cnt;
        end
        if (w_mode_rise) begin
          w_state_nxt = (r_state == MODE_SETHR) ? MODE_SETMIN : MODE_RUN;
        end else if (w_timeout) begin
          w_state_nxt = MODE_RUN;
        end else begin
          w_state_nxt = r_state;
        end
        w_sec_clr_nxt = (w_mode_rise && (r_state == MODE_SETMIN)) || w_timeout;
      end
      default: begin
        w_state_nxt = MODE_RUN;
        w_idle_nxt  = '0;
      end
    endcase
  end

  // A mode edge outranks an up edge and disarms repeat until the next real press.
  always_comb begin
    w_inc       = 1'b0;
    w_hold_nxt  = '0;
    w_first_nxt = 1'b1;
    w_armed_nxt = 1'b0;
    w_hold_last = r_first ? HOLD_LAST : REPEAT_LAST;
    if (!w_in_set || w_mode_rise) begin
      w_armed_nxt = 1'b0;
    end else if (w_up_rise) begin
      w_inc       = 1'b1;
      w_armed_nxt = 1'b1;
    end else if (r_armed && btn_up) begin
      w_armed_nxt = 1'b1;
      if (w_ms_tick && (r_hold_cnt == w_hold_last)) begin
        w_inc       = 1'b1;
        w_hold_nxt  = '0;
        w_first_nxt = 1'b0;
      end else if (w_ms_tick) begin
        w_hold_nxt  = r_hold_cnt + HW'(1);
        w_first_nxt = r_first;
      end else begin
        w_hold_nxt  = r_hold_cnt;
        w_first_nxt = r_first;
      end
    end else begin
      w_armed_nxt = 1'b0;
    end
  end

  // Digits restart visible on entering a set state and after every increment.
  always_comb begin
    w_blink_nxt = r_blink_cnt;
    w_phase_nxt = r_phase;
    if ((w_state_nxt == MODE_RUN) || (w_state_nxt != r_state) || w_inc) begin
      w_blink_nxt = '0;
      w_phase_nxt = 1'b0;
    end else if (w_ms_tick && (r_blink_cnt == BLINK_LAST)) begin
      w_blink_nxt = '0;
      w_phase_nxt = ~r_phase;
    end else if (w_ms_tick) begin
      w_blink_nxt = r_blink_cnt + BW'(1);
    end else begin
      w_blink_nxt = r_blink_cnt;
    end
  end

  always_comb begin
    w_blank_nxt = 4'b0000;
    case (w_state_nxt)
      MODE_SETHR:  w_blank_nxt = {w_phase_nxt, w_phase_nxt, 2'b00};
      MODE_SETMIN: w_blank_nxt = {2'b00, w_phase_nxt, w_phase_nxt};
      default:     w_blank_nxt = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= MODE_RUN;
      r_mode_prev <= 1'b1;
      r_up_prev   <= 1'b1;
      r_idle_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_first     <= 1'b1;
      r_armed     <= 1'b0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode_prev <= btn_mode;
      r_up_prev   <= btn_up;
      r_idle_cnt  <= w_idle_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_first     <= w_first_nxt;
      r_armed     <= w_armed_nxt;
      r_blink_cnt <= w_blink_nxt;
      r_phase     <= w_phase_nxt;
    end
  end

  // Outputs are registered against the next state so mode, mask and enable line up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hrup    <= 1'b0;
      r_minup   <= 1'b0;
      r_sec_clr <= 1'b0;
      r_clk_en  <= 1'b0;
      r_blank   <= 4'b0000;
    end else begin
      r_hrup    <= w_inc && (r_state == MODE_SETHR);
      r_minup   <= w_inc && (r_state == MODE_SETMIN);
      r_sec_clr <= w_sec_clr_nxt;
      r_clk_en  <= run_sw && (w_state_nxt == MODE_RUN);
      r_blank   <= w_blank_nxt;
    end
  end

  assign clk_en      = r_clk_en;
  assign hrup        = r_hrup;
  assign minup       = r_minup;
  assign sec_clr     = r_sec_clr;
  assign digit_blank = r_blank;
  assign mode        = r_state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl at 4 clocks per ms, with a millisecond-level
// reference model for modes, pulse counts, repeat times, blink phase and timeout.
module tb_time_set_ctrl;

  localparam int CLK_HZ     = 4000;
  localparam int HOLD_MS    = 500;
  localparam int REPEAT_MS  = 150;
  localparam int BLINK_MS   = 250;
  localparam int TIMEOUT_MS = 10000;
  localparam int CPM        = CLK_HZ / 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run_sw = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       clk_en, hrup, minup, sec_clr;
  logic [3:0] digit_blank;
  logic [1:0] mode;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int viol = 0;
  int m_mode = 0;
  int q_hr[$];
  int q_min[$];
  int q_sec[$];
  logic [3:0] q_pulse_blank[$];

  time_set_ctrl #(
    .CLK_HZ(CLK_HZ), .HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS),
    .BLINK_MS(BLINK_MS), .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run_sw(run_sw), .btn_mode(btn_mode), .btn_up(btn_up),
    .clk_en(clk_en), .hrup(hrup), .minup(minup), .sec_clr(sec_clr),
    .digit_blank(digit_blank), .mode(mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder plus always-true output relations, sampled mid-cycle.
  always @(negedge clk) begin
    if (hrup) begin q_hr.push_back(cyc); q_pulse_blank.push_back(digit_blank); end
    if (minup) begin q_min.push_back(cyc); q_pulse_blank.push_back(digit_blank); end
    if (sec_clr) q_sec.push_back(cyc);
    if (hrup && minup) viol++;
    if ((hrup || minup) && mode == 2'b00) viol++;
    if (sec_clr && mode != 2'b00) viol++;
    if (mode == 2'b11) viol++;
    if (mode == 2'b00 && digit_blank != 4'b0000) viol++;
    if (mode == 2'b01 && (digit_blank[1:0] != 2'b00 || digit_blank[3] != digit_blank[2])) viol++;
    if (mode == 2'b10 && (digit_blank[3:2] != 2'b00 || digit_blank[1] != digit_blank[0])) viol++;
  end

  function automatic int exp_pulses(input int d_ms);
    if (d_ms <= HOLD_MS) return 1;
    return 2 + (d_ms - 1 - HOLD_MS) / REPEAT_MS;
  endfunction

  function automatic int fire_ms(input int i);
    return (i == 0) ? 0 : HOLD_MS + (i - 1) * REPEAT_MS;
  endfunction

  function automatic logic [3:0] exp_blank(input int st, input int t_ms);
    logic p;
    p = ((t_ms / BLINK_MS) % 2) == 1;
    if (st == 1) return {p, p, 2'b00};
    if (st == 2) return {2'b00, p, p};
    return 4'b0000;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic press_mode(output int k);
    btn_mode = 1'b1;
    k = cyc;
    step(1);
    btn_mode = 1'b0;
    step(1);
    m_mode = (m_mode + 1) % 3;
  endtask

  task automatic clear_q();
    q_hr.delete(); q_min.delete(); q_sec.delete(); q_pulse_blank.delete();
  endtask

  task automatic test_reset();
    int k;
    logic [1:0] em;
    rst_n = 1'b0; btn_mode = 1'b1; btn_up = 1'b1; run_sw = 1'b1;
    step(3);
    tests_run++;
    if ({mode, clk_en, hrup, minup, sec_clr} !== 6'b0) begin
      tests_failed++; $display("FAIL reset_outputs: got %b want 000000", {mode, clk_en, hrup, minup, sec_clr});
    end
    tests_run++;
    if (digit_blank !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_blank: got %b want 0000", digit_blank);
    end
    rst_n = 1'b1;
    step(20);
    tests_run++;
    if (mode !== 2'b00) begin tests_failed++; $display("FAIL held_mode_ignored: got %b want 00", mode); end
    tests_run++;
    if (clk_en !== 1'b1) begin tests_failed++; $display("FAIL clk_en_run: got %b want 1", clk_en); end
    btn_mode = 1'b0; btn_up = 1'b0;
    step(3);
    press_mode(k);
    em = m_mode[1:0];
    tests_run++;
    if (clk_en !== 1'b0) begin tests_failed++; $display("FAIL clk_en_set: got %b want 0", clk_en); end
    btn_mode = 1'b1; step(1);
    btn_mode = 1'b0; step(1);
    m_mode = (m_mode + 1) % 3;
    press_mode(k);
    em = m_mode[1:0];
    btn_mode = 1'b1; step(1);
    tests_run++;
    if (mode !== 2'(m_mode + 1)) begin
      tests_failed++; $display("FAIL press_next_cycle: got %b want %b", mode, 2'(m_mode + 1));
    end
    btn_mode = 1'b0; step(1);
    m_mode = (m_mode + 1) % 3;
    tests_run++;
    if (mode !== 2'(m_mode)) begin tests_failed++; $display("FAIL reset_mode_track: got %b want %0d", mode, m_mode); end
    tests_run++;
    if (q_hr.size() + q_min.size() !== 0) begin
      tests_failed++; $display("FAIL reset_no_pulses: got %0d want 0", q_hr.size() + q_min.size());
    end
    tests_run++;
    if (em !== 2'b00) begin tests_failed++; $display("FAIL cycle_back_to_run: got %b want 00", em); end
  endtask

  task automatic test_tap();
    int k, len, exp_hr, exp_min, exp_sec;
    while (m_mode != 1) press_mode(k);
    clear_q();
    btn_up = 1'b1; k = cyc; step(3);
    btn_up = 1'b0; step(10);
    tests_run++;
    if (q_hr.size() != 1 || q_min.size() != 0) begin
      tests_failed++; $display("FAIL tap_count: got hr=%0d min=%0d want hr=1 min=0", q_hr.size(), q_min.size());
    end else begin
      tests_run++;
      if (q_hr[0] != k + 1) begin tests_failed++; $display("FAIL tap_latency: got %0d want %0d", q_hr[0] - k, 1); end
      tests_run++;
      if (q_pulse_blank[0] !== 4'b0000) begin
        tests_failed++; $display("FAIL tap_blank: got %b want 0000", q_pulse_blank[0]);
      end
    end
    clear_q();
    exp_hr = 0; exp_min = 0; exp_sec = 0;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        if (m_mode == 2) exp_sec++;
        press_mode(k);
      end
      len = $urandom_range(1, 40);
      btn_up = 1'b1; step(len);
      btn_up = 1'b0; step($urandom_range(2, 20));
      if (m_mode == 1) exp_hr++;
      if (m_mode == 2) exp_min++;
    end
    tests_run++;
    if (q_hr.size() != exp_hr || q_min.size() != exp_min) begin
      tests_failed++;
      $display("FAIL rand_taps: got hr=%0d min=%0d want hr=%0d min=%0d", q_hr.size(), q_min.size(), exp_hr, exp_min);
    end
    tests_run++;
    if (q_sec.size() != exp_sec) begin
      tests_failed++; $display("FAIL rand_taps_secclr: got %0d want %0d", q_sec.size(), exp_sec);
    end
    for (int i = 0; i < q_pulse_blank.size(); i++) begin
      tests_run++;
      if (q_pulse_blank[i] !== 4'b0000) begin
        tests_failed++; $display("FAIL rand_tap_blank: got %b want 0000", q_pulse_blank[i]);
      end
    end
  endtask

  task automatic test_blink();
    int k, p, t;
    logic [3:0] e;
    while (m_mode != 1) press_mode(k);
    btn_up = 1'b1; k = cyc; step(1);
    btn_up = 1'b0;
    p = k + 1;
    t = 0;
    for (int i = 0; i < 5; i++) begin
      t = t + $urandom_range(60, 300);
      if ((t % BLINK_MS) == 0 || (t % BLINK_MS) == 1 || (t % BLINK_MS) == BLINK_MS - 1) t = t + 3;
      wait_until(p + CPM * t);
      e = exp_blank(m_mode, t);
      tests_run++;
      if (digit_blank !== e) begin
        tests_failed++; $display("FAIL blink_at_%0dms: got %b want %b", t, digit_blank, e);
      end
    end
  endtask

  task automatic test_hold();
    int k, p, off, d, exp_hr, exp_min;
    while (m_mode != 2) press_mode(k);
    clear_q();
    btn_up = 1'b1; k = cyc; p = k + 1;
    step(CPM * 1000);
    btn_up = 1'b0; step(20);
    tests_run++;
    if (q_min.size() != exp_pulses(1000) || q_hr.size() != 0) begin
      tests_failed++; $display("FAIL hold_count: got min=%0d hr=%0d want min=%0d hr=0", q_min.size(), q_hr.size(), exp_pulses(1000));
    end
    for (int i = 0; i < q_min.size() && i < 5; i++) begin
      off = q_min[i] - p;
      tests_run++;
      if (off < CPM * (fire_ms(i) - 1) || off > CPM * fire_ms(i)) begin
        tests_failed++; $display("FAIL hold_time_%0d: got %0d cycles want %0d ms", i, off, fire_ms(i));
      end
    end
    clear_q();
    exp_hr = 0; exp_min = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin press_mode(k); press_mode(k); end
      d = $urandom_range(100, 800);
      if (d >= HOLD_MS && ((d - HOLD_MS) % REPEAT_MS) == 0) d = d + 1;
      btn_up = 1'b1; step(CPM * d);
      btn_up = 1'b0; step(10);
      if (m_mode == 1) exp_hr += exp_pulses(d);
      if (m_mode == 2) exp_min += exp_pulses(d);
    end
    tests_run++;
    if (q_hr.size() != exp_hr || q_min.size() != exp_min) begin
      tests_failed++;
      $display("FAIL rand_holds: got hr=%0d min=%0d want hr=%0d min=%0d", q_hr.size(), q_min.size(), exp_hr, exp_min);
    end
  endtask

  task automatic test_simultaneous();
    int k;
    while (m_mode != 1) press_mode(k);
    clear_q();
    btn_mode = 1'b1; btn_up = 1'b1; step(1);
    m_mode = 2;
    tests_run++;
    if (mode !== 2'b10) begin tests_failed++; $display("FAIL simul_mode: got %b want 10", mode); end
    btn_mode = 1'b0;
    step(CPM * 600);
    btn_up = 1'b0; step(5);
    tests_run++;
    if (q_hr.size() + q_min.size() != 0) begin
      tests_failed++; $display("FAIL simul_no_pulse: got %0d want 0", q_hr.size() + q_min.size());
    end
  endtask

  task automatic test_timeout();
    int k, p, off;
    logic prev;
    while (m_mode != 1) press_mode(k);
    clear_q();
    p = k + 1;
    run_sw = 1'b1;
    wait_until(p + CPM * (TIMEOUT_MS - 10));
    tests_run++;
    if (mode !== 2'b01 || clk_en !== 1'b0 || q_sec.size() != 0) begin
      tests_failed++; $display("FAIL timeout_early: got mode=%b clk_en=%b sec=%0d want 01 0 0", mode, clk_en, q_sec.size());
    end
    while (q_sec.size() == 0 && cyc < p + CPM * TIMEOUT_MS + 40) step(1);
    step(4);
    m_mode = 0;
    tests_run++;
    if (q_sec.size() != 1) begin
      tests_failed++; $display("FAIL timeout_secclr_count: got %0d want 1", q_sec.size());
    end else begin
      off = q_sec[0] - p;
      tests_run++;
      if (off < CPM * (TIMEOUT_MS - 1) || off > CPM * TIMEOUT_MS + 1) begin
        tests_failed++; $display("FAIL timeout_time: got %0d cycles want %0d ms", off, TIMEOUT_MS);
      end
    end
    tests_run++;
    if (mode !== 2'b00) begin tests_failed++; $display("FAIL timeout_mode: got %b want 00", mode); end
    for (int i = 0; i < 16; i++) begin
      run_sw = $urandom_range(0, 1) == 1;
      prev = run_sw;
      step(1);
      tests_run++;
      if (clk_en !== prev) begin tests_failed++; $display("FAIL clk_en_track: got %b want %b", clk_en, prev); end
    end
  endtask

  task automatic test_reset_burst();
    int k, n_seen;
    bit fired;
    while (m_mode != 1) press_mode(k);
    n_seen = 0; fired = 0;
    btn_up = 1'b1;
    for (int c = 0; c < CPM * 720 && !fired; c++) begin
      @(posedge clk); #2;
      if (hrup) begin
        n_seen++;
        if (n_seen == 3) begin
          rst_n = 1'b0; #1;
          fired = 1;
          tests_run++;
          if ({hrup, minup, mode, digit_blank} !== 8'b0) begin
            tests_failed++; $display("FAIL burst_reset_async: got %b want 00000000", {hrup, minup, mode, digit_blank});
          end
        end
      end
    end
    tests_run++;
    if (!fired) begin tests_failed++; $display("FAIL burst_wait: got %0d pulses want 3", n_seen); end
    rst_n = 1'b0;
    m_mode = 0;
    step(3);
    rst_n = 1'b1;
    clear_q();
    step(CPM * 1000);
    tests_run++;
    if (q_hr.size() + q_min.size() != 0 || mode !== 2'b00) begin
      tests_failed++; $display("FAIL burst_after_reset: got pulses=%0d mode=%b want 0 00", q_hr.size() + q_min.size(), mode);
    end
    btn_up = 1'b0; step(3);
    press_mode(k);
    btn_up = 1'b1; step(1);
    tests_run++;
    if (hrup !== 1'b1 || mode !== 2'(m_mode)) begin
      tests_failed++; $display("FAIL burst_repress: got hrup=%b mode=%b want 1 %0d", hrup, mode, m_mode);
    end
    btn_up = 1'b0; step(3);
  endtask

  task automatic test_invariants();
    tests_run++;
    if (viol != 0) begin tests_failed++; $display("FAIL output_invariants: got %0d violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_tap();
    test_blink();
    test_hold();
    test_simultaneous();
    test_timeout();
    test_reset_burst();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
